dim_overlay_ctrl: RTL

- Sequences the pause-screen dimming applied by the pixel colour-conversion stage.
- On a pause request, ramps the dim amount up one step at a time on frame boundaries; on resume, ramps it back down.
- Supplies the converter with `to_black`, a per-pixel dim level and a registered in-window flag for the undimmed score box.
- Sits between game-state logic and the VGA pixel path, clocked by the pixel clock.

---
 rtl/dim_overlay_if.sv | 28 ++
 rtl/dim_overlay_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/dim_overlay_if.sv
// Bundle between game/pixel-timing logic and the dim overlay sequencer.
// master: requests, frame timing, pixel position in; slave: dim controls out.
interface dim_overlay_if;
  logic        pause_req;
  logic        resume_req;
  logic        frame_start;
  logic [11:0] hdata;
  logic [11:0] vdata;
  logic        to_black;
  logic [3:0]  dim_level;
  logic        in_window;
  logic        busy;
  logic        dimmed;

  modport master (
    output pause_req, resume_req, frame_start,
    output hdata, vdata,
    input  to_black, dim_level, in_window,
    input  busy, dimmed
  );

  modport slave (
    input  pause_req, resume_req, frame_start,
    input  hdata, vdata,
    output to_black, dim_level, in_window,
    output busy, dimmed
  );
endinterface

// File: rtl/dim_overlay_ctrl.sv
// Pause-screen dim sequencer: ramps dim level on frame boundaries.
// Ports: clk, reset (sync, high), bus (dim_overlay_if.slave).
module dim_overlay_ctrl #(
  parameter int WIN_X0          = 283,
  parameter int WIN_Y0          = 220,
  parameter int WIN_X1          = 483,
  parameter int WIN_Y1          = 355,
  parameter int MAX_DIM         = 2,
  parameter int FRAMES_PER_STEP = 4
) (
  input logic          clk,
  input logic          reset,
  dim_overlay_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    FADE_IN,
    DIMMED,
    FADE_OUT
  } state_e;

  localparam logic [3:0]  MAX_L  = 4'(MAX_DIM);
  localparam logic [7:0]  STEP_L = 8'(FRAMES_PER_STEP - 1);
  localparam logic [11:0] X0 = 12'(WIN_X0);
  localparam logic [11:0] X1 = 12'(WIN_X1);
  localparam logic [11:0] Y0 = 12'(WIN_Y0);
  localparam logic [11:0] Y1 = 12'(WIN_Y1);

  state_e     state_q, state_d;
  logic [3:0] level_q, level_d;
  logic [7:0] cnt_q, cnt_d;
  logic       pend_pause_q, pend_pause_d;
  logic       pend_resume_q, pend_resume_d;
  logic       to_black_q, to_black_d;
  logic       in_window_q, in_window_d;

  // requests seen this cycle, merged into the pending flags
  logic       pp, pr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      level_q       <= 4'd0;
      cnt_q         <= 8'd0;
      pend_pause_q  <= 1'b0;
      pend_resume_q <= 1'b0;
      to_black_q    <= 1'b0;
      in_window_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      level_q       <= level_d;
      cnt_q         <= cnt_d;
      pend_pause_q  <= pend_pause_d;
      pend_resume_q <= pend_resume_d;
      to_black_q    <= to_black_d;
      in_window_q   <= in_window_d;
    end
  end

  always_comb begin
    pp = pend_pause_q;
    pr = pend_resume_q;
    // simultaneous pause+resume cancel out and leave flags as they were
    if (bus.pause_req && !bus.resume_req) begin
      pp = 1'b1;
      pr = 1'b0;
    end else if (bus.resume_req && !bus.pause_req) begin
      pp = 1'b0;
      pr = 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    level_d       = level_q;
    cnt_d         = cnt_q;
    pend_pause_d  = pp;
    pend_resume_d = pr;
    if (bus.frame_start) begin
      // every frame boundary consumes whatever is pending
      pend_pause_d  = 1'b0;
      pend_resume_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          level_d = 4'd0;
          if (pp) begin
            state_d = FADE_IN;
            level_d = 4'd1;
            cnt_d   = 8'd0;
          end
        end
        FADE_IN: begin
          if (pr) begin
            state_d = FADE_OUT;
            cnt_d   = 8'd0;
          end else if (level_q >= MAX_L) begin
            // only reachable with MAX_DIM=1
            state_d = DIMMED;
            level_d = MAX_L;
            cnt_d   = 8'd0;
          end else if (cnt_q >= STEP_L) begin
            cnt_d   = 8'd0;
            level_d = level_q + 4'd1;
            if (level_q + 4'd1 >= MAX_L) begin
              state_d = DIMMED;
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        DIMMED: begin
          level_d = MAX_L;
          if (pr) begin
            cnt_d   = 8'd0;
            level_d = MAX_L - 4'd1;
            if (MAX_L == 4'd1) begin
              state_d = IDLE;
            end else begin
              state_d = FADE_OUT;
            end
          end
        end
        FADE_OUT: begin
          if (pp) begin
            state_d = FADE_IN;
            cnt_d   = 8'd0;
          end else if (level_q == 4'd0) begin
            state_d = IDLE;
            cnt_d   = 8'd0;
          end else if (cnt_q >= STEP_L) begin
            cnt_d   = 8'd0;
            level_d = level_q - 4'd1;
            if (level_q == 4'd1) begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: begin
          state_d = IDLE;
          level_d = 4'd0;
          cnt_d   = 8'd0;
        end
      endcase
    end
  end

  always_comb begin
    to_black_d  = (state_d != IDLE);
    in_window_d = (bus.hdata >= X0) && (bus.hdata <= X1) &&
                  (bus.vdata >= Y0) && (bus.vdata <= Y1);
  end

  assign bus.to_black  = to_black_q;
  assign bus.dim_level = level_q;
  assign bus.in_window = in_window_q;
  assign bus.busy      = (state_q == FADE_IN) || (state_q == FADE_OUT);
  assign bus.dimmed    = (state_q == DIMMED);

endmodule
